axi_w_order_sched: RTL and testbench

- Write-data channel scheduler for an AXI3-style interconnect slave port.
- Records the order of AW grants (master index, AWID, AWLEN) in an internal order FIFO, then routes W beats from exactly one master at a time to the shared slave W channel, in AW-grant order.
- Generates S_WID from the recorded AWID and checks that beat counts match AWLEN.
- Sits after the AW arbiter and in front of the slave W channel.

---
 rtl/axi_w_order_sched.sv | 217 +++++++++++++++++++++
 tb/tb_axi_w_order_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_w_order_sched.sv
// axi_w_order_sched: W-channel scheduler for an AXI3-style slave port.
// AW grants are queued as {master index, AWID, AWLEN} in an order FIFO.
// W beats are then routed from one master at a time, in AW-grant order.
// S_WID is regenerated from the queued AWID, and beat counts are checked
// against AWLEN, with a sticky LEN_ERR flag on mismatch.
module axi_w_order_sched #(
  parameter int unsigned NUM_M      = 2,
  parameter int unsigned WIDTH_ID   = 4,
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned IDX_W     = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1,
  localparam int unsigned STRB_W    = WIDTH_DATA / 8
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        AW_HS,
  input  logic [IDX_W-1:0]            AW_IDX,
  input  logic [WIDTH_ID-1:0]         AW_ID,
  input  logic [7:0]                  AW_LEN,
  output logic                        AW_ORDER_READY,
  input  logic [NUM_M-1:0]            M_WVALID,
  input  logic [NUM_M-1:0]            M_WLAST,
  input  logic [NUM_M*WIDTH_DATA-1:0] M_WDATA,
  input  logic [NUM_M*STRB_W-1:0]     M_WSTRB,
  output logic [NUM_M-1:0]            M_WREADY,
  output logic [WIDTH_ID-1:0]         S_WID,
  output logic [WIDTH_DATA-1:0]       S_WDATA,
  output logic [STRB_W-1:0]           S_WSTRB,
  output logic                        S_WLAST,
  output logic                        S_WVALID,
  input  logic                        S_WREADY,
  output logic [CNT_W-1:0]            ORDER_CNT,
  output logic                        LEN_ERR
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0]    idx;
    logic [WIDTH_ID-1:0] id;
    logic [7:0]          len;
  } ent_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  ent_t                mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
  logic [WIDTH_ID-1:0] cur_id_q, cur_id_d;
  logic [7:0]          cur_len_q, cur_len_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic                len_err_q, len_err_d;

  ent_t                head;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                beat;
  logic                sel_valid;
  logic                sel_last;
  logic [WIDTH_DATA-1:0] sel_data;
  logic [STRB_W-1:0]   sel_strb;

  assign head           = mem_q[rd_ptr_q];
  assign empty          = (cnt_q == '0);
  assign full           = (cnt_q == FULL_CNT);
  assign AW_ORDER_READY = !full;
  assign ORDER_CNT      = cnt_q;
  assign LEN_ERR        = len_err_q;
  assign push           = AW_HS && !full;
  assign beat           = (state_q == ST_BURST) && sel_valid && S_WREADY;
  assign pop            = ((state_q == ST_IDLE) && !empty) ||
                          (beat && sel_last && !empty);

  // Select the W signals of the master that owns the current burst.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_strb  = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (cur_idx_q == IDX_W'(i)) begin
        sel_valid = M_WVALID[i];
        sel_last  = M_WLAST[i];
        sel_data  = M_WDATA[i*WIDTH_DATA +: WIDTH_DATA];
        sel_strb  = M_WSTRB[i*STRB_W +: STRB_W];
      end
    end
  end

  // Drive the slave W channel and the owning master's WREADY; quiet in IDLE.
  always_comb begin
    S_WVALID = 1'b0;
    S_WLAST  = 1'b0;
    S_WDATA  = '0;
    S_WSTRB  = '0;
    S_WID    = '0;
    M_WREADY = '0;
    if (state_q == ST_BURST) begin
      S_WVALID = sel_valid;
      S_WLAST  = sel_last;
      S_WDATA  = sel_data;
      S_WSTRB  = sel_strb;
      S_WID    = cur_id_q;
      for (int unsigned i = 0; i < NUM_M; i++) begin
        if (cur_idx_q == IDX_W'(i)) begin
          M_WREADY[i] = S_WREADY;
        end
      end
    end
  end

  // Next-state for FIFO pointers, occupancy, burst FSM and length checker.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    cur_id_d   = cur_id_q;
    cur_len_d  = cur_len_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          cur_idx_d  = head.idx;
          cur_id_d   = head.id;
          cur_len_d  = head.len;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (beat) begin
          if (sel_last && (beat_cnt_q != cur_len_q)) begin
            len_err_d = 1'b1;
          end
          if (!sel_last && (beat_cnt_q == cur_len_q)) begin
            len_err_d = 1'b1;
          end
          if (beat_cnt_q != 8'hFF) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
          // The burst ends only on WLAST; a queued head is taken in the same
          // cycle so consecutive bursts run without a bubble.
          if (sel_last) begin
            if (!empty) begin
              cur_idx_d  = head.idx;
              cur_id_d   = head.id;
              cur_len_d  = head.len;
              beat_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      cur_idx_q  <= '0;
      cur_id_q   <= '0;
      cur_len_q  <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      cur_id_q   <= cur_id_d;
      cur_len_q  <= cur_len_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  // Order FIFO storage; contents are qualified by the count, so no reset.
  always_ff @(posedge ACLK) begin
    if (!ARESET && push) begin
      mem_q[wr_ptr_q] <= '{idx: AW_IDX, id: AW_ID, len: AW_LEN};
    end
  end

endmodule

// File: tb/tb_axi_w_order_sched.sv
// Directed bench for axi_w_order_sched (NUM_M=2, WIDTH_ID=4, 32-bit data, DEPTH=8).
module tb_axi_w_order_sched;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AW_HS;
  logic [0:0]  AW_IDX;
  logic [3:0]  AW_ID;
  logic [7:0]  AW_LEN;
  logic        AW_ORDER_READY;
  logic [1:0]  M_WVALID;
  logic [1:0]  M_WLAST;
  logic [63:0] M_WDATA;
  logic [7:0]  M_WSTRB;
  logic [1:0]  M_WREADY;
  logic [3:0]  S_WID;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WLAST;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [3:0]  ORDER_CNT;
  logic        LEN_ERR;

  int n_total = 0;
  int n_pass  = 0;

  axi_w_order_sched #(
    .NUM_M      (2),
    .WIDTH_ID   (4),
    .WIDTH_DATA (32),
    .DEPTH      (8)
  ) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .AW_HS          (AW_HS),
    .AW_IDX         (AW_IDX),
    .AW_ID          (AW_ID),
    .AW_LEN         (AW_LEN),
    .AW_ORDER_READY (AW_ORDER_READY),
    .M_WVALID       (M_WVALID),
    .M_WLAST        (M_WLAST),
    .M_WDATA        (M_WDATA),
    .M_WSTRB        (M_WSTRB),
    .M_WREADY       (M_WREADY),
    .S_WID          (S_WID),
    .S_WDATA        (S_WDATA),
    .S_WSTRB        (S_WSTRB),
    .S_WLAST        (S_WLAST),
    .S_WVALID       (S_WVALID),
    .S_WREADY       (S_WREADY),
    .ORDER_CNT      (ORDER_CNT),
    .LEN_ERR        (LEN_ERR)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic aw(input int idx, input int id, input int len);
    AW_HS  = 1'b1;
    AW_IDX = idx[0:0];
    AW_ID  = id[3:0];
    AW_LEN = len[7:0];
    tick();
    AW_HS  = 1'b0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1; AW_HS = 1'b0; AW_IDX = '0; AW_ID = '0; AW_LEN = '0;
    M_WVALID = '0; M_WLAST = '0; M_WDATA = '0; M_WSTRB = '0; S_WREADY = 1'b0;

    // Reset state
    repeat (2) tick();
    ARESET = 1'b0;
    repeat (2) tick();
    #2;
    chk("rst_ready", 32'(AW_ORDER_READY), 32'd1);
    chk("rst_cnt", 32'(ORDER_CNT), 32'd0);
    chk("rst_svalid", 32'(S_WVALID), 32'd0);
    chk("rst_mready", 32'(M_WREADY), 32'd0);
    chk("rst_lenerr", 32'(LEN_ERR), 32'd0);

    // Single 4-beat burst from master 1
    S_WREADY = 1'b1;
    M_WDATA  = 64'h1234_5678_9ABC_DEF0;
    M_WVALID = 2'b10;
    aw(1, 5, 3);
    #2;
    chk("b1_cnt_queued", 32'(ORDER_CNT), 32'd1);
    chk("b1_idle_valid", 32'(S_WVALID), 32'd0);
    chk("b1_idle_data", S_WDATA, 32'd0);
    chk("b1_idle_mready", 32'(M_WREADY), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      M_WVALID = 2'b10;
      M_WLAST  = (k == 3) ? 2'b10 : 2'b00;
      M_WDATA  = {32'hA000_0000 + 32'(k), 32'h1111_1111};
      M_WSTRB  = {4'(k + 1), 4'h0};
      #2;
      chk("b1_valid", 32'(S_WVALID), 32'd1);
      chk("b1_wid", 32'(S_WID), 32'h5);
      chk("b1_data", S_WDATA, 32'hA000_0000 + 32'(k));
      chk("b1_strb", 32'(S_WSTRB), 32'(k + 1));
      chk("b1_mready", 32'(M_WREADY), 32'b10);
      chk("b1_last", 32'(S_WLAST), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    M_WVALID = 2'b10; M_WLAST = 2'b00;
    #2;
    chk("b1_end_valid", 32'(S_WVALID), 32'd0);
    chk("b1_end_mready", 32'(M_WREADY), 32'd0);
    chk("b1_end_wid", 32'(S_WID), 32'd0);
    chk("b1_end_lenerr", 32'(LEN_ERR), 32'd0);
    M_WVALID = 2'b00;

    // Back-to-back bursts: master 0 (2 beats) then master 1 (1 beat)
    aw(0, 2, 1);
    aw(1, 7, 0);
    M_WVALID = 2'b11; M_WLAST = 2'b10;
    M_WDATA  = {32'hB000_0001, 32'hA000_0001};
    #2;
    chk("bb_wid0", 32'(S_WID), 32'h2);
    chk("bb_mready0", 32'(M_WREADY), 32'b01);
    chk("bb_last0", 32'(S_WLAST), 32'd0);
    chk("bb_cnt", 32'(ORDER_CNT), 32'd1);
    chk("bb_data0", S_WDATA, 32'hA000_0001);
    tick();
    M_WLAST = 2'b11;
    M_WDATA = {32'hB000_0001, 32'hA000_0002};
    #2;
    chk("bb_mready1", 32'(M_WREADY), 32'b01);
    chk("bb_last1", 32'(S_WLAST), 32'd1);
    chk("bb_data1", S_WDATA, 32'hA000_0002);
    tick();
    #2;
    chk("bb_wid2", 32'(S_WID), 32'h7);
    chk("bb_mready2", 32'(M_WREADY), 32'b10);
    chk("bb_valid2", 32'(S_WVALID), 32'd1);
    chk("bb_data2", S_WDATA, 32'hB000_0001);
    chk("bb_cnt2", 32'(ORDER_CNT), 32'd0);
    tick();
    #2;
    chk("bb_end_valid", 32'(S_WVALID), 32'd0);
    chk("bb_end_mready", 32'(M_WREADY), 32'd0);
    M_WVALID = 2'b00; M_WLAST = 2'b00;

    // Fill: first entry is taken into BURST, eight more fill the FIFO
    for (int i = 0; i < 9; i++) aw(0, i, 0);
    #2;
    chk("fill_cnt", 32'(ORDER_CNT), 32'd8);
    chk("fill_ready", 32'(AW_ORDER_READY), 32'd0);
    aw(0, 9, 0);
    #2;
    chk("fill_ovf_cnt", 32'(ORDER_CNT), 32'd8);
    chk("fill_cur_wid", 32'(S_WID), 32'd0);
    for (int j = 0; j < 9; j++) begin
      M_WVALID = 2'b01; M_WLAST = 2'b01;
      #2;
      if (j == 1) begin
        chk("fill_ready_after", 32'(AW_ORDER_READY), 32'd1);
        chk("fill_cnt_after", 32'(ORDER_CNT), 32'd7);
      end
      chk("fill_wid", 32'(S_WID), 32'(j));
      tick();
    end
    M_WVALID = 2'b01; M_WLAST = 2'b01;
    #2;
    chk("fill_drain_mready", 32'(M_WREADY), 32'd0);
    chk("fill_drain_cnt", 32'(ORDER_CNT), 32'd0);
    chk("fill_lenerr", 32'(LEN_ERR), 32'd0);
    M_WVALID = 2'b00; M_WLAST = 2'b00;

    // Length error: len=3 but WLAST on the second beat
    aw(0, 3, 3);
    tick();
    M_WVALID = 2'b01; M_WLAST = 2'b00;
    #2;
    chk("le_first_lenerr", 32'(LEN_ERR), 32'd0);
    tick();
    M_WLAST = 2'b01;
    #2;
    chk("le_early_last", 32'(S_WLAST), 32'd1);
    tick();
    #2;
    chk("le_set", 32'(LEN_ERR), 32'd1);
    chk("le_ended", 32'(M_WREADY), 32'd0);
    M_WVALID = 2'b00; M_WLAST = 2'b00;
    aw(1, 4, 1);
    tick();
    M_WVALID = 2'b10;
    #2;
    chk("le_next_wid", 32'(S_WID), 32'h4);
    tick();
    M_WLAST = 2'b10;
    tick();
    M_WVALID = 2'b00; M_WLAST = 2'b00;
    #2;
    chk("le_sticky", 32'(LEN_ERR), 32'd1);
    chk("le_cnt", 32'(ORDER_CNT), 32'd0);

    // Count reached without WLAST: len=0, WLAST only on the second beat
    do_reset();
    #2;
    chk("le2_rst_clear", 32'(LEN_ERR), 32'd0);
    aw(0, 6, 0);
    tick();
    M_WVALID = 2'b01; M_WLAST = 2'b00;
    #2;
    chk("le2_pre", 32'(LEN_ERR), 32'd0);
    tick();
    #2;
    chk("le2_set", 32'(LEN_ERR), 32'd1);
    chk("le2_still_burst", 32'(M_WREADY), 32'b01);
    chk("le2_wid", 32'(S_WID), 32'h6);
    M_WLAST = 2'b01;
    tick();
    #2;
    chk("le2_ended", 32'(M_WREADY), 32'd0);
    M_WVALID = 2'b00; M_WLAST = 2'b00;

    // Reset mid-burst with three entries queued
    do_reset();
    for (int i = 1; i <= 4; i++) aw(0, i, 3);
    M_WVALID = 2'b01;
    #2;
    chk("mr_cnt", 32'(ORDER_CNT), 32'd3);
    chk("mr_mready", 32'(M_WREADY), 32'b01);
    tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    #2;
    chk("mr_valid", 32'(S_WVALID), 32'd0);
    chk("mr_cnt0", 32'(ORDER_CNT), 32'd0);
    chk("mr_mready0", 32'(M_WREADY), 32'd0);
    chk("mr_ready", 32'(AW_ORDER_READY), 32'd1);
    tick();
    #2;
    chk("mr_stay_idle", 32'(S_WVALID), 32'd0);
    chk("mr_stay_cnt", 32'(ORDER_CNT), 32'd0);
    M_WVALID = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
